dec_entry_to_signed: RTL

Serial decimal-entry accumulator: accepts a sign key and up to three BCD digits one at a time, then converts the entry to an N-bit two's-complement value on an enter strobe. It is the input-side counterpart of the signed-binary-to-BCD/seven-segment display path. Its `value` output feeds the calculator datapath and the display chain, and `sign_n` drives the sign LED directly.

---
 rtl/dec_entry_to_signed.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dec_entry_to_signed.sv
// Serial decimal-entry accumulator: sign key plus up to MAX_DIGITS BCD digits, converted to an
// N-bit two's-complement value on enter. Optional build macro: DEC_ENTRY_SATURATE_EN.
module dec_entry_to_signed #(
    parameter int N          = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_digit_valid,
    input  logic [3:0]   i_digit,
    input  logic         i_neg_key,
    input  logic         i_enter,
    input  logic         i_clear,
    output logic [N-1:0] o_value,
    output logic         o_value_valid,
    output logic         o_error,
    output logic [1:0]   o_digit_count,
    output logic         o_sign_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam int          VW      = (N > 10) ? N : 10;
    localparam logic [31:0] POS_LIM = 32'((2 ** (N - 1)) - 1);
    localparam logic [31:0] NEG_LIM = 32'(2 ** (N - 1));
    localparam logic [1:0]  CNT_MAX = 2'(MAX_DIGITS);
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N - 1){1'b0}}};

    // Decimal shift-in: mag*10 + d as (mag<<3)+(mag<<1)+d, never exceeds 999 for legal entries
    function automatic logic [9:0] mul10_add(input logic [9:0] m, input logic [3:0] d);
        logic [9:0] sh3;
        logic [9:0] sh1;
        sh3 = m << 3;
        sh1 = m << 1;
        return sh3 + sh1 + {6'd0, d};
    endfunction

    function automatic logic in_range(input logic [9:0] m, input logic n);
        logic ok;
        if (n) begin
            ok = (32'(m) <= NEG_LIM);
        end else begin
            ok = (32'(m) <= POS_LIM);
        end
        return ok;
    endfunction

    function automatic logic [N-1:0] to_twos(input logic [9:0] m, input logic n);
        logic [VW-1:0] ext;
        logic [VW-1:0] res;
        ext = VW'(m);
        if (n) begin
            res = ~ext + {{(VW - 1){1'b0}}, 1'b1};
        end else begin
            res = ext;
        end
        return res[N-1:0];
    endfunction

    state_t         r_state;
    logic [9:0]     r_mag;
    logic           r_neg;
    logic [1:0]     r_cnt;
    logic [N-1:0]   r_value;
    logic           r_value_valid;
    logic           r_error;

    state_t         w_state_nxt;
    logic [9:0]     w_mag_nxt;
    logic           w_neg_nxt;
    logic [1:0]     w_cnt_nxt;
    logic [N-1:0]   w_value_nxt;
    logic           w_valid_nxt;
    logic           w_error_nxt;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entry datapath and committed-output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mag         <= 10'd0;
            r_neg         <= 1'b0;
            r_cnt         <= 2'd0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_mag         <= w_mag_nxt;
            r_neg         <= w_neg_nxt;
            r_cnt         <= w_cnt_nxt;
            r_value       <= w_value_nxt;
            r_value_valid <= w_valid_nxt;
            r_error       <= w_error_nxt;
        end
    end

    // Next-state and datapath update; only the highest-priority strobe acts each cycle
    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_neg_nxt   = r_neg;
        w_cnt_nxt   = r_cnt;
        w_value_nxt = r_value;
        w_valid_nxt = 1'b0;
        w_error_nxt = r_error;

        if (i_clear) begin
            w_state_nxt = ST_IDLE;
            w_mag_nxt   = 10'd0;
            w_neg_nxt   = 1'b0;
            w_cnt_nxt   = 2'd0;
            w_error_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_enter) begin
                        w_state_nxt = r_state;
                    end else if (i_neg_key) begin
                        w_state_nxt = ST_ENTRY;
                        w_mag_nxt   = 10'd0;
                        w_neg_nxt   = 1'b1;
                        w_cnt_nxt   = 2'd0;
                    end else if (i_digit_valid) begin
                        if (i_digit > 4'd9) begin
                            w_state_nxt = ST_ERR;
                            w_error_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_ENTRY;
                            w_mag_nxt   = {6'd0, i_digit};
                            w_neg_nxt   = 1'b0;
                            w_cnt_nxt   = 2'd1;
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                ST_ENTRY: begin
                    if (i_enter) begin
                        if (r_cnt == 2'd0) begin
                            w_state_nxt = ST_ERR;
                            w_error_nxt = 1'b1;
                        end else if (in_range(r_mag, r_neg)) begin
                            w_state_nxt = ST_DONE;
                            w_value_nxt = to_twos(r_mag, r_neg);
                            w_valid_nxt = 1'b1;
                        end else begin
`ifdef DEC_ENTRY_SATURATE_EN
                            w_state_nxt = ST_DONE;
                            w_value_nxt = r_neg ? SAT_NEG : SAT_POS;
                            w_valid_nxt = 1'b1;
`else
                            w_state_nxt = ST_ERR;
                            w_error_nxt = 1'b1;
`endif
                        end
                    end else if (i_neg_key) begin
                        w_neg_nxt = ~r_neg;
                    end else if (i_digit_valid) begin
                        if ((i_digit > 4'd9) || (r_cnt == CNT_MAX)) begin
                            w_state_nxt = ST_ERR;
                            w_error_nxt = 1'b1;
                        end else begin
                            w_mag_nxt = mul10_add(r_mag, i_digit);
                            w_cnt_nxt = r_cnt + 2'd1;
                        end
                    end else begin
                        w_state_nxt = ST_ENTRY;
                    end
                end
                ST_ERR: begin
                    w_state_nxt = ST_ERR;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        o_value       = r_value;
        o_value_valid = r_value_valid;
        o_error       = r_error;
        o_digit_count = r_cnt;
        o_sign_n      = ~r_neg;
    end

endmodule
